// File: rtl/fpu_pkg.sv
// Shared FPU constants, slot record layout and latency helpers used by dest tracking and forwarding.
package fpu_pkg;

  localparam int unsigned FPU_STAGES = 6;
  localparam int unsigned FPU_REG_W  = 5;
  localparam int unsigned FPU_LAT_W  = 3;
  localparam int unsigned FPU_CNT_W  = 3;

  typedef struct packed {
    logic                 valid;
    logic [FPU_REG_W-1:0] rd;
    logic [FPU_LAT_W-1:0] rem;
  } fpu_slot_t;

  // Remaining-latency decrement, saturating at zero.
  function automatic logic [FPU_LAT_W-1:0] fpu_rem_dec(input logic [FPU_LAT_W-1:0] rem);
    return (rem == '0) ? '0 : rem - FPU_LAT_W'(1);
  endfunction

  // Slot-1 rem for an issued op: latency clamped to 1..FPU_STAGES, minus the issue move.
  function automatic logic [FPU_LAT_W-1:0] fpu_issue_rem(input logic [FPU_LAT_W-1:0] lat);
    if (lat == '0) return '0;
    if (lat > FPU_LAT_W'(FPU_STAGES)) return FPU_LAT_W'(FPU_STAGES - 1);
    return lat - FPU_LAT_W'(1);
  endfunction

endpackage

// File: rtl/fpu_dest_slot.sv
// One tracking slot: reset/clear, hold, or load with optional saturating rem decrement.
module fpu_dest_slot
  import fpu_pkg::*;
#(
  parameter bit DEC_ON_LOAD = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      load,
  input  fpu_slot_t d,
  output fpu_slot_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q.valid <= d.valid;
      q.rd    <= d.rd;
      q.rem   <= DEC_ON_LOAD ? fpu_rem_dec(d.rem) : d.rem;
    end
  end

endmodule

// File: rtl/fpu_dest_track.sv
// Destination-tag tracker for FPU ops across the six post-issue stages.
// Optional stall statistics counter enabled by defining FPU_DEST_STATS_EN.
module fpu_dest_track
  import fpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [FPU_REG_W-1:0] issue_rd,
  input  logic [FPU_LAT_W-1:0] issue_lat,
  input  logic                 pipe_stall,
  input  logic                 flush,
  output logic [FPU_REG_W-1:0] rdi_buf_1,
  output logic [FPU_REG_W-1:0] rdi_buf_2,
  output logic [FPU_REG_W-1:0] rdi_buf_3,
  output logic [FPU_REG_W-1:0] rdi_buf_4,
  output logic [FPU_REG_W-1:0] rdi_buf_5,
  output logic [FPU_REG_W-1:0] rdi_buf_6,
  output logic                 legal_1,
  output logic                 legal_2,
  output logic                 legal_3,
  output logic                 legal_4,
  output logic                 legal_5,
  output logic                 legal_6,
  output logic                 busy_1,
  output logic                 busy_2,
  output logic                 busy_3,
  output logic                 busy_4,
  output logic                 busy_5,
  output logic                 busy_6,
  output logic                 wb_valid,
  output logic [FPU_REG_W-1:0] wb_rd,
  output logic [FPU_CNT_W-1:0] inflight_cnt,
  output logic [31:0]          stat_stall_cnt
);

  localparam int unsigned LAST = FPU_STAGES - 1;

  fpu_slot_t                  slot_q [FPU_STAGES];
  fpu_slot_t                  slot_d [FPU_STAGES];
  logic                       advance;
  logic                       retire_c;
  logic [FPU_STAGES-1:0]      nxt_valid;
  logic [FPU_CNT_W-1:0]       nxt_cnt;
  logic [FPU_STAGES-1:0]      legal_v;
  logic [FPU_STAGES-1:0]      busy_v;

  // Flush overrides stall; both suppress the shift.
  assign advance = !pipe_stall && !flush;

  always_comb begin
    slot_d[0].valid = issue_valid;
    slot_d[0].rd    = issue_rd;
    slot_d[0].rem   = fpu_issue_rem(issue_lat);
    for (int k = 1; k < FPU_STAGES; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  for (genvar k = 0; k < FPU_STAGES; k++) begin : g_slot
    fpu_dest_slot #(
      .DEC_ON_LOAD((k != 0) ? 1'b1 : 1'b0)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .load  (advance),
      .d     (slot_d[k]),
      .q     (slot_q[k])
    );
    assign legal_v[k] = slot_q[k].valid && (slot_q[k].rem == '0);
    assign busy_v[k]  = slot_q[k].valid && (slot_q[k].rem != '0);
  end

  // Next-state valid vector mirrors the slot update so the count stays aligned.
  always_comb begin
    nxt_valid = '0;
    nxt_cnt   = '0;
    if (flush) begin
      nxt_valid = '0;
    end else if (pipe_stall) begin
      for (int k = 0; k < FPU_STAGES; k++) nxt_valid[k] = slot_q[k].valid;
    end else begin
      nxt_valid[0] = issue_valid;
      for (int k = 1; k < FPU_STAGES; k++) nxt_valid[k] = slot_q[k-1].valid;
    end
    for (int k = 0; k < FPU_STAGES; k++) nxt_cnt = nxt_cnt + FPU_CNT_W'(nxt_valid[k]);
  end

  assign retire_c = advance && slot_q[LAST].valid && (slot_q[LAST].rem == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      inflight_cnt <= '0;
    end else begin
      wb_valid     <= retire_c;
      wb_rd        <= retire_c ? slot_q[LAST].rd : '0;
      inflight_cnt <= nxt_cnt;
    end
  end

`ifdef FPU_DEST_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pipe_stall && (inflight_cnt != '0)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_stall_cnt = 32'd0;
`endif

  assign rdi_buf_1 = slot_q[0].rd;
  assign rdi_buf_2 = slot_q[1].rd;
  assign rdi_buf_3 = slot_q[2].rd;
  assign rdi_buf_4 = slot_q[3].rd;
  assign rdi_buf_5 = slot_q[4].rd;
  assign rdi_buf_6 = slot_q[5].rd;

  assign legal_1 = legal_v[0];
  assign legal_2 = legal_v[1];
  assign legal_3 = legal_v[2];
  assign legal_4 = legal_v[3];
  assign legal_5 = legal_v[4];
  assign legal_6 = legal_v[5];

  assign busy_1 = busy_v[0];
  assign busy_2 = busy_v[1];
  assign busy_3 = busy_v[2];
  assign busy_4 = busy_v[3];
  assign busy_5 = busy_v[4];
  assign busy_6 = busy_v[5];

endmodule
